// File: rtl/conv_feeder.sv
// conv_feeder
//   Loads KernelSize weight words from the weight memory, then streams a
//   row_in x col_in image from the data memory in raster order (column
//   fastest). Both memories have a one-cycle read latency. Each output word
//   is presented in the cycle after its address is issued.
//
// Optional feature:
//   CONV_FEEDER_PAUSE_EN - adds input 'pause'. While pause is high, no new
//   address is issued and no counter advances. A read already in flight
//   still produces its output word.
//
// Ports:
//   Clk, Rst              clock (rising edge), asynchronous active-high reset
//   start                 one-cycle request, honoured only in IDLE
//   row_in, col_in        image size, latched on an accepted start
//   w_addr / w_rdata      weight memory read port
//   d_addr / d_rdata      data memory read port
//   weight_out/_valid     weight word stream
//   data_out/_valid       data word stream
//   row_count, col_count  position of data_out
//   busy, done            busy while an operation runs; done pulses at the end
//
// State  | meaning
// IDLE   | waiting for start
// LOAD_W | issuing weight addresses 0..KernelSize-1
// STREAM | issuing data addresses 0..row*col-1
// DONE   | last read in flight; next cycle pulses done and returns to IDLE
module conv_feeder #(
    parameter int DataWidth   = 32,
    parameter int InputDim    = 4,
    parameter int KernelSize  = 9,
    parameter int MaxRowWidth = 9,
    parameter int MaxColWidth = 9,
    parameter int AddrWidth   = 18
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          start,
    input  logic [MaxRowWidth-1:0]        row_in,
    input  logic [MaxColWidth-1:0]        col_in,
`ifdef CONV_FEEDER_PAUSE_EN
    input  logic                          pause,
`endif
    output logic [AddrWidth-1:0]          w_addr,
    input  logic [InputDim*DataWidth-1:0] w_rdata,
    output logic [AddrWidth-1:0]          d_addr,
    input  logic [InputDim*DataWidth-1:0] d_rdata,
    output logic [InputDim*DataWidth-1:0] weight_out,
    output logic                          weight_valid,
    output logic [InputDim*DataWidth-1:0] data_out,
    output logic                          data_valid,
    output logic [MaxColWidth-1:0]        col_count,
    output logic [MaxRowWidth-1:0]        row_count,
    output logic                          busy,
    output logic                          done
);

    localparam int WordWidth = InputDim * DataWidth;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD_W = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [AddrWidth-1:0]   WLast   = AddrWidth'(KernelSize - 1);
    localparam logic [AddrWidth-1:0]   AddrOne = 1;
    localparam logic [MaxRowWidth-1:0] RowOne  = 1;
    localparam logic [MaxColWidth-1:0] ColOne  = 1;

    logic [1:0]             state;
    logic [AddrWidth-1:0]   addr;
    logic [MaxRowWidth-1:0] row_lat;
    logic [MaxRowWidth-1:0] row_iss;
    logic [MaxColWidth-1:0] col_lat;
    logic [MaxColWidth-1:0] col_iss;
    logic                   w_pend;
    logic                   d_pend;
    logic [WordWidth-1:0]   weight_hold;
    logic [WordWidth-1:0]   data_hold;
    logic                   advance;
    logic                   issue_w;
    logic                   issue_d;
    logic                   last_w;
    logic                   col_wrap;
    logic                   last_d;
    logic                   empty;

`ifdef CONV_FEEDER_PAUSE_EN
    assign advance = ~pause;
`else
    assign advance = 1'b1;
`endif

    assign issue_w  = (state == LOAD_W) && advance;
    assign issue_d  = (state == STREAM) && advance;
    assign last_w   = (addr == WLast);
    assign col_wrap = (col_iss == col_lat - ColOne);
    assign last_d   = col_wrap && (row_iss == row_lat - RowOne);
    assign empty    = (row_lat == '0) || (col_lat == '0);

    // Addresses are driven only while their phase is active so the idle bus
    // reads as zero, including immediately on reset.
    assign w_addr = (state == LOAD_W) ? addr : '0;
    assign d_addr = (state == STREAM) ? addr : '0;

    assign weight_valid = w_pend;
    assign data_valid   = d_pend;

    // The read data arrives in the valid cycle itself; outside valid cycles
    // the last captured word is replayed.
    assign weight_out = w_pend ? w_rdata : weight_hold;
    assign data_out   = d_pend ? d_rdata : data_hold;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= IDLE;
            addr        <= '0;
            row_lat     <= '0;
            row_iss     <= '0;
            col_lat     <= '0;
            col_iss     <= '0;
            w_pend      <= 1'b0;
            d_pend      <= 1'b0;
            weight_hold <= '0;
            data_hold   <= '0;
            col_count   <= '0;
            row_count   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            w_pend <= issue_w;
            d_pend <= issue_d;
            done   <= 1'b0;
            if (w_pend) weight_hold <= w_rdata;
            if (d_pend) data_hold <= d_rdata;

            case (state)
                IDLE: begin
                    if (start) begin
                        row_lat <= row_in;
                        col_lat <= col_in;
                        addr    <= '0;
                        row_iss <= '0;
                        col_iss <= '0;
                        busy    <= 1'b1;
                        state   <= LOAD_W;
                    end
                end
                LOAD_W: begin
                    if (advance) begin
                        if (last_w) begin
                            addr  <= '0;
                            state <= empty ? DONE : STREAM;
                        end else begin
                            addr <= addr + AddrOne;
                        end
                    end
                end
                STREAM: begin
                    if (advance) begin
                        // Counts travel with the read so they line up with data_out.
                        col_count <= col_iss;
                        row_count <= row_iss;
                        addr      <= addr + AddrOne;
                        if (col_wrap) begin
                            col_iss <= '0;
                            row_iss <= row_iss + RowOne;
                        end else begin
                            col_iss <= col_iss + ColOne;
                        end
                        if (last_d) state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_feeder.sv
module tb_conv_feeder;

    localparam int DW = 32;
    localparam int ID = 4;
    localparam int KS = 9;
    localparam int RW = 9;
    localparam int CW = 9;
    localparam int AW = 18;
    localparam int WW = ID * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [RW-1:0] row_in = '0;
    logic [CW-1:0] col_in = '0;
    logic          pause = 1'b0;
    logic [AW-1:0] w_addr;
    logic [AW-1:0] d_addr;
    logic [WW-1:0] w_rdata = '0;
    logic [WW-1:0] d_rdata = '0;
    logic [WW-1:0] weight_out;
    logic [WW-1:0] data_out;
    logic          weight_valid;
    logic          data_valid;
    logic [CW-1:0] col_count;
    logic [RW-1:0] row_count;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    conv_feeder dut (
        .Clk(clk),
        .Rst(rst),
        .start(start),
        .row_in(row_in),
        .col_in(col_in),
`ifdef CONV_FEEDER_PAUSE_EN
        .pause(pause),
`endif
        .w_addr(w_addr),
        .w_rdata(w_rdata),
        .d_addr(d_addr),
        .d_rdata(d_rdata),
        .weight_out(weight_out),
        .weight_valid(weight_valid),
        .data_out(data_out),
        .data_valid(data_valid),
        .col_count(col_count),
        .row_count(row_count),
        .busy(busy),
        .done(done)
    );

    function automatic logic [WW-1:0] wpat(input logic [AW-1:0] a);
        logic [WW-1:0] v;
        v = '0;
        for (int i = 0; i < ID; i++) v[i*DW +: DW] = 32'hA000_0000 | (32'(i) << 16) | 32'(a);
        return v;
    endfunction

    function automatic logic [WW-1:0] dpat(input logic [AW-1:0] a);
        logic [WW-1:0] v;
        v = '0;
        for (int i = 0; i < ID; i++) v[i*DW +: DW] = 32'(a) + (32'(i) << 24);
        return v;
    endfunction

    // Memories with one-cycle read latency.
    always @(posedge clk) begin
        w_rdata <= wpat(w_addr);
        d_rdata <= dpat(d_addr);
    end

    typedef struct {
        logic [WW-1:0] data;
        int            r;
        int            c;
    } dexp_t;

    typedef struct {
        int r;
        int c;
        int mode;   // 0 plain, 1 stray start in STREAM, 2 pause in STREAM
        int lat;    // edges after the start edge until done is visible
    } vec_t;

    logic [WW-1:0] exp_w[$];
    dexp_t         exp_d[$];
    int            checks = 0;
    int            errors = 0;
    int            w_cnt = 0;
    int            d_cnt = 0;
    int            done_cnt = 0;
    logic [WW-1:0] last_w = '0;
    logic [WW-1:0] last_d = '0;

    task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Scoreboard side: every valid word is popped against the queued expectation.
    always @(negedge clk) begin
        if (rst) begin
            last_w = '0;
            last_d = '0;
        end else begin
            chk("valid_overlap", WW'(weight_valid & data_valid), '0);
            if (weight_valid) begin
                w_cnt++;
                chk("weight_queue", WW'(exp_w.size() != 0), WW'(1));
                if (exp_w.size() != 0) begin
                    last_w = exp_w.pop_front();
                    chk("weight_out", weight_out, last_w);
                end
            end else begin
                chk("weight_hold", weight_out, last_w);
            end
            if (data_valid) begin
                dexp_t e;
                d_cnt++;
                chk("data_queue", WW'(exp_d.size() != 0), WW'(1));
                if (exp_d.size() != 0) begin
                    e = exp_d.pop_front();
                    last_d = e.data;
                    chk("data_out", data_out, e.data);
                    chk("row_count", WW'(row_count), WW'(e.r));
                    chk("col_count", WW'(col_count), WW'(e.c));
                end
            end else begin
                chk("data_hold", data_out, last_d);
            end
            if (done) done_cnt++;
        end
    end

    task automatic push_expect(input int r, input int c);
        for (int k = 0; k < KS; k++) exp_w.push_back(wpat(AW'(k)));
        for (int i = 0; i < r; i++)
            for (int j = 0; j < c; j++)
                exp_d.push_back('{dpat(AW'(i * c + j)), i, j});
    endtask

    task automatic run_op(input int r, input int c, input int mode, input int exp_lat);
        int lat;
        bit busy_ok;
        push_expect(r, c);
        w_cnt = 0;
        d_cnt = 0;
        done_cnt = 0;
        @(negedge clk);
        start  = 1'b1;
        row_in = RW'(r);
        col_in = CW'(c);
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            start = (mode == 1 && n == 14);
            pause = (mode == 2 && n >= 12 && n <= 14);
        end
        start = 1'b0;
        pause = 1'b0;
        chk("latency", WW'(lat), WW'(exp_lat));
        chk("busy_during", WW'(busy_ok), WW'(1));
        chk("busy_at_done", WW'(busy), '0);
        @(negedge clk);
        #1;
        chk("done_width", WW'(done), '0);
        chk("done_count", WW'(done_cnt), WW'(1));
        chk("weight_pulses", WW'(w_cnt), WW'(KS));
        chk("data_pulses", WW'(d_cnt), WW'(r * c));
        chk("queues_empty", WW'(exp_w.size() + exp_d.size()), '0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_weight_out"}, weight_out, '0);
        chk({tag, "_data_out"}, data_out, '0);
        chk({tag, "_valids"}, WW'({weight_valid, data_valid}), '0);
        chk({tag, "_counts"}, WW'({row_count, col_count}), '0);
        chk({tag, "_busy_done"}, WW'({busy, done}), '0);
        chk({tag, "_addrs"}, WW'({w_addr, d_addr}), '0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[$];
        bit   reached;
        vecs.push_back('{3, 4, 0, 22});
        vecs.push_back('{0, 5, 0, 10});
        vecs.push_back('{1, 1, 0, 11});
        vecs.push_back('{2, 7, 0, 24});
        vecs.push_back('{4, 0, 0, 10});
        vecs.push_back('{3, 4, 1, 22});
`ifdef CONV_FEEDER_PAUSE_EN
        vecs.push_back('{3, 4, 2, 25});
`endif

        #1;
        check_zero_outputs("reset");
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Back-to-back operations without any reset in between.
        foreach (vecs[v]) run_op(vecs[v].r, vecs[v].c, vecs[v].mode, vecs[v].lat);

        // Reset while the fifth data word is on the output.
        push_expect(3, 4);
        w_cnt = 0;
        d_cnt = 0;
        reached = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        row_in = RW'(3);
        col_in = CW'(4);
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            #1;
            if (d_cnt >= 5) begin
                reached = 1'b1;
                break;
            end
        end
        chk("reached_fifth_word", WW'(reached), WW'(1));
        chk("fifth_word_valid", WW'(data_valid), WW'(1));
        rst = 1'b1;
        #1;
        check_zero_outputs("midreset");
        exp_w.delete();
        exp_d.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #1;
        check_zero_outputs("postreset");
        run_op(3, 4, 0, 22);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
